// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_ST, OWN_AUX} owner_e;

  typedef enum logic {ARB_IDLE, ARB_WAIT} state_e;

  typedef struct packed {
    logic ld;
    logic st;
    logic aux;
  } grant_t;

  localparam logic [3:0] STRB_NONE  = 4'b1111;
  localparam grant_t     GRANT_NONE = '{ld: 1'b0, st: 1'b0, aux: 1'b0};

  function automatic owner_e grant_to_owner(input grant_t g);
    if (g.ld) begin
      return OWN_LD;
    end else if (g.st) begin
      return OWN_ST;
    end else if (g.aux) begin
      return OWN_AUX;
    end else begin
      return OWN_NONE;
    end
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Fixed-priority winner selection; a saturated starvation flag lifts store or aux above load.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic   ld_valid,
  input  logic   st_valid,
  input  logic   aux_valid,
  input  logic   st_sat,
  input  logic   aux_sat,
  output grant_t grant
);

  // One-hot grant: promoted store, promoted aux, then load > store > aux.
  always_comb begin
    grant = GRANT_NONE;
    if (st_valid && st_sat) begin
      grant.st = 1'b1;
    end else if (aux_valid && aux_sat) begin
      grant.aux = 1'b1;
    end else if (ld_valid) begin
      grant.ld = 1'b1;
    end else if (st_valid) begin
      grant.st = 1'b1;
    end else if (aux_valid) begin
      grant.aux = 1'b1;
    end else begin
      grant = GRANT_NONE;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between LSU load, LSU store-drain and an aux master,
// one transaction in flight, response routed back to the owner.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_ld_req_valid,
  output logic              lsu_ld_req_ready,
  output logic              lsu_ld_data_valid,
  output logic [DATA_W-1:0] lsu_ld_data,
  input  logic              lsu_st_req_valid,
  output logic              lsu_st_req_ready,
  input  logic [3:0]        lsu_st_strb,
  input  logic [DATA_W-1:0] lsu_st_data,
  output logic              lsu_st_done,
  input  logic              aux_req_valid,
  output logic              aux_req_ready,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [3:0]        aux_strb,
  output logic              aux_rsp_valid,
  output logic [DATA_W-1:0] aux_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_strb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              spurious_rsp
);

  localparam int              CNT_W = 4;
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  state_e           state_r, state_nxt_s;
  owner_e           owner_r;
  logic [CNT_W-1:0] st_cnt_r, aux_cnt_r;
  logic             spurious_r;
  grant_t           grant_s;
  logic             hs_s;

  dm_arb_pick u_pick (
    .ld_valid  (lsu_ld_req_valid),
    .st_valid  (lsu_st_req_valid),
    .aux_valid (aux_req_valid),
    .st_sat    (st_cnt_r == LIM_C),
    .aux_sat   (aux_cnt_r == LIM_C),
    .grant     (grant_s)
  );

  assign hs_s = (state_r == ARB_IDLE) && mem_req_valid && mem_req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: grant moves to WAIT, any response returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: state_nxt_s = hs_s ? ARB_WAIT : ARB_IDLE;
      ARB_WAIT: state_nxt_s = mem_rsp_valid ? ARB_IDLE : ARB_WAIT;
      default:  state_nxt_s = ARB_IDLE;
    endcase
  end

  // Owner, starvation counters and the sticky spurious-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r    <= OWN_NONE;
      st_cnt_r   <= {CNT_W{1'b0}};
      aux_cnt_r  <= {CNT_W{1'b0}};
      spurious_r <= 1'b0;
    end else begin
      if (hs_s) begin
        owner_r <= grant_to_owner(grant_s);
        if (grant_s.st) begin
          st_cnt_r <= {CNT_W{1'b0}};
        end else if (lsu_st_req_valid && (st_cnt_r != LIM_C)) begin
          st_cnt_r <= st_cnt_r + 4'd1;
        end
        if (grant_s.aux) begin
          aux_cnt_r <= {CNT_W{1'b0}};
        end else if (aux_req_valid && (aux_cnt_r != LIM_C)) begin
          aux_cnt_r <= aux_cnt_r + 4'd1;
        end
      end else if ((state_r == ARB_WAIT) && mem_rsp_valid) begin
        owner_r <= OWN_NONE;
      end
      if ((state_r == ARB_IDLE) && mem_rsp_valid) begin
        spurious_r <= 1'b1;
      end
    end
  end

  assign spurious_rsp = spurious_r;

  // Request mux toward memory and response routing back to the owner.
  always_comb begin
    mem_req_valid     = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = {ADDR_W{1'b0}};
    mem_wdata         = {DATA_W{1'b0}};
    mem_strb          = 4'b0000;
    lsu_ld_req_ready  = 1'b0;
    lsu_st_req_ready  = 1'b0;
    aux_req_ready     = 1'b0;
    lsu_ld_data_valid = 1'b0;
    lsu_ld_data       = {DATA_W{1'b0}};
    lsu_st_done       = 1'b0;
    aux_rsp_valid     = 1'b0;
    aux_rsp_data      = {DATA_W{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        mem_req_valid    = lsu_ld_req_valid | lsu_st_req_valid | aux_req_valid;
        lsu_ld_req_ready = grant_s.ld  & mem_req_ready;
        lsu_st_req_ready = grant_s.st  & mem_req_ready;
        aux_req_ready    = grant_s.aux & mem_req_ready;
        if (grant_s.ld) begin
          mem_addr = lsu_addr;
          mem_strb = STRB_NONE;
        end else if (grant_s.st) begin
          mem_we    = 1'b1;
          mem_addr  = lsu_addr;
          mem_wdata = lsu_st_data;
          mem_strb  = lsu_st_strb;
        end else if (grant_s.aux) begin
          mem_we    = aux_we;
          mem_addr  = aux_addr;
          mem_wdata = aux_we ? aux_wdata : {DATA_W{1'b0}};
          mem_strb  = aux_we ? aux_strb : STRB_NONE;
        end else begin
          mem_strb = 4'b0000;
        end
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          case (owner_r)
            OWN_LD: begin
              lsu_ld_data_valid = 1'b1;
              lsu_ld_data       = mem_rsp_data;
            end
            OWN_ST:  lsu_st_done = 1'b1;
            OWN_AUX: begin
              aux_rsp_valid = 1'b1;
              aux_rsp_data  = mem_rsp_data;
            end
            default: lsu_st_done = 1'b0;
          endcase
        end else begin
          lsu_st_done = 1'b0;
        end
      end
      default: mem_req_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter (default parameters, STARVE_LIM=4).
module tb_dm_port_arbiter;

  logic        clk, rst;
  logic [31:0] lsu_addr;
  logic        lsu_ld_req_valid, lsu_ld_req_ready, lsu_ld_data_valid;
  logic [31:0] lsu_ld_data;
  logic        lsu_st_req_valid, lsu_st_req_ready, lsu_st_done;
  logic [3:0]  lsu_st_strb;
  logic [31:0] lsu_st_data;
  logic        aux_req_valid, aux_req_ready, aux_we, aux_rsp_valid;
  logic [31:0] aux_addr, aux_wdata, aux_rsp_data;
  logic [3:0]  aux_strb;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_strb;
  logic        spurious_rsp;

  int tests_run = 0;
  int tests_failed = 0;

  dm_port_arbiter dut (
    .clk(clk), .rst(rst), .lsu_addr(lsu_addr),
    .lsu_ld_req_valid(lsu_ld_req_valid), .lsu_ld_req_ready(lsu_ld_req_ready),
    .lsu_ld_data_valid(lsu_ld_data_valid), .lsu_ld_data(lsu_ld_data),
    .lsu_st_req_valid(lsu_st_req_valid), .lsu_st_req_ready(lsu_st_req_ready),
    .lsu_st_strb(lsu_st_strb), .lsu_st_data(lsu_st_data), .lsu_st_done(lsu_st_done),
    .aux_req_valid(aux_req_valid), .aux_req_ready(aux_req_ready), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_strb(aux_strb),
    .aux_rsp_valid(aux_rsp_valid), .aux_rsp_data(aux_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .spurious_rsp(spurious_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return a response pulse for the transaction currently in WAIT.
  task automatic rsp_cycle(input logic [31:0] data);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    #1;
  endtask

  logic exp_aux;

  initial begin
    rst = 1'b0;
    lsu_addr = 32'h0; lsu_ld_req_valid = 1'b0; lsu_st_req_valid = 1'b0;
    lsu_st_strb = 4'h0; lsu_st_data = 32'h0;
    aux_req_valid = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0; aux_strb = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    #2;
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_ld_ready", lsu_ld_req_ready, 1'b0);
    check_eq("rst_spurious", spurious_rsp, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    #10 rst = 1'b1;
    step();

    // Single load, response two cycles after the grant.
    lsu_ld_req_valid = 1'b1; lsu_addr = 32'h100; mem_req_ready = 1'b1;
    #1;
    check_eq("ld_ready", lsu_ld_req_ready, 1'b1);
    check_eq("ld_req_valid", mem_req_valid, 1'b1);
    check_eq("ld_addr", mem_addr, 32'h100);
    check_eq("ld_strb", mem_strb, 4'b1111);
    check_eq("ld_we", mem_we, 1'b0);
    step();
    lsu_ld_req_valid = 1'b0;
    #1;
    check_eq("ld_wait_req", mem_req_valid, 1'b0);
    step();
    rsp_cycle(32'hDEADBEEF);
    check_eq("ld_rsp_valid", lsu_ld_data_valid, 1'b1);
    check_eq("ld_rsp_data", lsu_ld_data, 32'hDEADBEEF);
    check_eq("ld_no_st_done", lsu_st_done, 1'b0);
    check_eq("ld_no_aux_rsp", aux_rsp_valid, 1'b0);
    step();
    mem_rsp_valid = 1'b0;

    // Simultaneous load, store and aux write: served LD, ST, AUX.
    lsu_ld_req_valid = 1'b1; lsu_st_req_valid = 1'b1; aux_req_valid = 1'b1;
    lsu_addr = 32'h40; lsu_st_data = 32'h11223344; lsu_st_strb = 4'b0000;
    aux_we = 1'b1; aux_addr = 32'h200; aux_wdata = 32'h55; aux_strb = 4'b0011;
    #1;
    check_eq("sim1_ld_ready", lsu_ld_req_ready, 1'b1);
    check_eq("sim1_st_ready", lsu_st_req_ready, 1'b0);
    check_eq("sim1_aux_ready", aux_req_ready, 1'b0);
    check_eq("sim1_we", mem_we, 1'b0);
    step();
    lsu_ld_req_valid = 1'b0;
    #1;
    check_eq("sim1_wait_st_ready", lsu_st_req_ready, 1'b0);
    rsp_cycle(32'h1);
    check_eq("sim1_rsp", lsu_ld_data_valid, 1'b1);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("sim2_st_ready", lsu_st_req_ready, 1'b1);
    check_eq("sim2_we", mem_we, 1'b1);
    check_eq("sim2_wdata", mem_wdata, 32'h11223344);
    check_eq("sim2_strb", mem_strb, 4'b0000);
    step();
    lsu_st_req_valid = 1'b0;
    rsp_cycle(32'h0);
    check_eq("sim2_done", lsu_st_done, 1'b1);
    check_eq("sim2_no_ld_rsp", lsu_ld_data_valid, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("sim3_aux_ready", aux_req_ready, 1'b1);
    check_eq("sim3_we", mem_we, 1'b1);
    check_eq("sim3_addr", mem_addr, 32'h200);
    check_eq("sim3_wdata", mem_wdata, 32'h55);
    check_eq("sim3_strb", mem_strb, 4'b0011);
    step();
    aux_req_valid = 1'b0;
    rsp_cycle(32'h77);
    check_eq("sim3_aux_rsp", aux_rsp_valid, 1'b1);
    check_eq("sim3_no_st_done", lsu_st_done, 1'b0);
    step();
    mem_rsp_valid = 1'b0;

    // Starvation: load and aux read continuously; 5th grant goes to aux, 6th back to load.
    lsu_ld_req_valid = 1'b1; aux_req_valid = 1'b1; aux_we = 1'b0;
    lsu_addr = 32'h300; aux_addr = 32'h400;
    for (int i = 0; i < 6; i++) begin
      exp_aux = (i == 4);
      #1;
      check_eq($sformatf("starve%0d_ld_ready", i), lsu_ld_req_ready, !exp_aux);
      check_eq($sformatf("starve%0d_aux_ready", i), aux_req_ready, exp_aux);
      check_eq($sformatf("starve%0d_addr", i), mem_addr, exp_aux ? 32'h400 : 32'h300);
      check_eq($sformatf("starve%0d_strb", i), mem_strb, 4'b1111);
      step();
      rsp_cycle(32'hA0 + 32'(i));
      check_eq($sformatf("starve%0d_wait_ready", i), lsu_ld_req_ready, 1'b0);
      check_eq($sformatf("starve%0d_aux_rsp", i), aux_rsp_valid, exp_aux);
      check_eq($sformatf("starve%0d_ld_rsp", i), lsu_ld_data_valid, !exp_aux);
      step();
      mem_rsp_valid = 1'b0;
    end
    lsu_ld_req_valid = 1'b0; aux_req_valid = 1'b0;

    // Backpressure: store held for three cycles, granted on the fourth.
    lsu_st_req_valid = 1'b1; lsu_st_strb = 4'b1110; lsu_st_data = 32'h000000AB;
    lsu_addr = 32'h80; mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp%0d_req_valid", i), mem_req_valid, 1'b1);
      check_eq($sformatf("bp%0d_st_ready", i), lsu_st_req_ready, 1'b0);
      check_eq($sformatf("bp%0d_wdata", i), mem_wdata, 32'h000000AB);
      check_eq($sformatf("bp%0d_strb", i), mem_strb, 4'b1110);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    check_eq("bp_grant", lsu_st_req_ready, 1'b1);
    step();
    lsu_st_req_valid = 1'b0;
    rsp_cycle(32'h0);
    check_eq("bp_done", lsu_st_done, 1'b1);
    step();
    mem_rsp_valid = 1'b0;

    // Response while idle.
    rsp_cycle(32'h1234);
    check_eq("spur_no_ld", lsu_ld_data_valid, 1'b0);
    check_eq("spur_no_st", lsu_st_done, 1'b0);
    check_eq("spur_no_aux", aux_rsp_valid, 1'b0);
    check_eq("spur_before_edge", spurious_rsp, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("spur_set", spurious_rsp, 1'b1);
    step(); step();
    check_eq("spur_sticky", spurious_rsp, 1'b1);

    // Reset while waiting on an aux read.
    aux_req_valid = 1'b1; aux_we = 1'b0; aux_addr = 32'h500;
    #1;
    check_eq("rw_aux_ready", aux_req_ready, 1'b1);
    step();
    aux_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rw_spurious_clr", spurious_rsp, 1'b0);
    check_eq("rw_req_valid", mem_req_valid, 1'b0);
    check_eq("rw_aux_rsp", aux_rsp_valid, 1'b0);
    rst = 1'b1;
    step();
    rsp_cycle(32'hCAFE);
    check_eq("rw_late_rsp", aux_rsp_valid, 1'b0);
    check_eq("rw_late_data", aux_rsp_data, 32'h0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("rw_spurious_set", spurious_rsp, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between three requesters: the LSU load channel, the LSU store-drain channel and an auxiliary master (debug/DMA).
- Sits between the LSU DM interface and the DM SRAM wrapper.
- Allows one transaction outstanding at a time.
- Arbitration is fixed priority with starvation counters, and the response is routed back to the owner of the transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIM, 4, number of lost grants after which a waiting store/aux requester is promoted (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- lsu_addr  in  ADDR_W  LSU shared request address
- lsu_ld_req_valid  in  1  LSU load request
- lsu_ld_req_ready  out  1  load granted this cycle
- lsu_ld_data_valid  out  1  load response pulse
- lsu_ld_data  out  DATA_W  load response data
- lsu_st_req_valid  in  1  LSU store request
- lsu_st_req_ready  out  1  store granted this cycle
- lsu_st_strb  in  4  active-low byte write mask (0000 = full word)
- lsu_st_data  in  DATA_W  store data, already lane-aligned
- lsu_st_done  out  1  store write-ack pulse
- aux_req_valid  in  1  aux request
- aux_req_ready  out  1  aux granted
- aux_we  in  1  1 = write
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux write data
- aux_strb  in  4  aux active-low byte mask
- aux_rsp_valid  out  1  aux response pulse
- aux_rsp_data  out  DATA_W  aux read data (undefined on write ack)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_strb  out  4  active-low byte mask; 1111 on reads
- mem_rsp_valid  in  1  response/ack, one pulse per accepted request
- mem_rsp_data  in  DATA_W  read data
- spurious_rsp  out  1  sticky: mem_rsp_valid seen while IDLE

Behaviour:
- FSM states: IDLE, WAIT_RSP. Reset state is IDLE.
- Reset values:
  - owner = NONE.
  - Both starvation counters = 0.
  - spurious_rsp = 0.
  - All valid/ready outputs = 0.
  - Data outputs = 0.
- IDLE, requests present:
  - mem_req_valid = OR of the three request valids.
  - The winner's fields drive mem_*. All outputs are combinational from the current inputs and state.
- Winner priority, highest first:
  - store, if st_cnt == STARVE_LIM;
  - aux, if aux_cnt == STARVE_LIM;
  - load;
  - store;
  - aux.
- Grant rules:
  - Winner's *_req_ready = mem_req_ready. Losers' ready = 0.
  - Handshake = mem_req_valid && mem_req_ready.
  - On handshake: latch owner (LD/ST/AUX), go to WAIT_RSP.
- Starvation counters, updated on each handshake:
  - Each of st_cnt/aux_cnt whose requester was valid but lost increments, saturating at STARVE_LIM.
  - The granted requester's counter clears.
  - A requester not valid at the handshake keeps its counter.
- WAIT_RSP:
  - mem_req_valid = 0; all *_req_ready = 0.
  - On mem_rsp_valid, exactly one of lsu_ld_data_valid / lsu_st_done / aux_rsp_valid pulses, per owner. Data passes through combinationally.
  - Same cycle: owner ← NONE, next state IDLE.
  - The next grant is possible the following cycle, so back-to-back transactions cost request + latency + 1 idle-eval cycle. There is no same-cycle re-grant.
- Memory side:
  - Reads drive mem_we = 0, mem_strb = 1111, mem_wdata = 0.
  - LSU store: mem_we = 1, strb/data passed unchanged.
- mem_rsp_valid while IDLE: ignored (no response pulse), spurious_rsp ← 1 until reset.
- Requests held through a lost arbitration stay pending. The arbiter never drops a requester's valid.
- mem_req_ready low: request stays asserted; winner may change next cycle if inputs change (no lock before handshake).
- Async reset mid-WAIT_RSP: returns to IDLE, and the in-flight response is lost. The memory must be reset in the same domain.

Decomposition:
- Shared package dm_arb_pkg:
  - owner enum {OWN_NONE, OWN_LD, OWN_ST, OWN_AUX};
  - state enum {ARB_IDLE, ARB_WAIT};
  - constant STRB_NONE = 4'b1111.
- Sub-module dm_arb_pick: purely combinational priority/starvation selector, taking the valids and both saturation flags and producing a one-hot grant.
- The counters, FSM and muxes stay in the top module.

Test Plan:
- Single load: ld_valid, addr=0x100, ready=1; rsp after 2 cycles with data=0xDEADBEEF → ld_ready pulse at cycle 0, mem_strb=1111, lsu_ld_data_valid=1 with 0xDEADBEEF at cycle 2, no other response pulse.
- Simultaneous ld+st+aux → order LD, ST, AUX; each issues only after the previous response; mem_we=0,1,aux_we respectively.
- Starvation, STARVE_LIM=4: load and aux valid continuously, each load issued again after its response → 4 loads granted, 5th grant goes to aux, aux_cnt returns to 0.
- Backpressure: mem_req_ready=0 for 3 cycles with st valid, strb=1110, data=0x000000AB → request held stable, st_ready=0, grant on 4th cycle, lsu_st_done on its ack.
- mem_rsp_valid pulsed while IDLE → no response output, spurious_rsp=1 and stays 1.
- Reset asserted while in WAIT_RSP owned by AUX → outputs zero immediately; a later rsp pulse produces no aux_rsp_valid and sets spurious_rsp.
